seg_display_driver: RTL and testbench
=====================================

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 Parameter: SCAN_DIV, default 100000, clk cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter: WIDTH, default 32, display value width; fixed 8 hex digits.
REQ-003 Port: clk  input  1  single system clock; all state on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: ledData  input  WIDTH  value written by the CPU ecall path.
REQ-006 Port: ledValid  input  1  one-cycle strobe; ledData is valid this cycle.
REQ-007 Port: halt  input  1  CPU halted level.
REQ-008 Port: an  output  8  digit enables, active-low, one-hot-low when lit.
REQ-009 Port: seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-010 Port: shown  output  WIDTH  currently latched display value.

Function
REQ-011 FSM states SHALL be BLANK, SCAN and HALTED.
REQ-012 BLANK SHALL go to SCAN on ledValid, and to HALTED on halt; halt wins if both are asserted.
REQ-013 SCAN SHALL go to HALTED on halt.
REQ-014 HALTED SHALL be left only via rst.
REQ-015 shown SHALL load ledData on ledValid in BLANK or SCAN, and on ledValid coincident with halt.
REQ-016 ledValid SHALL be ignored in HALTED.
REQ-017 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; tick is asserted at terminal count.
REQ-018 Prescaler SHALL run in all states.
REQ-019 Digit index idx (3 bit) SHALL increment on tick and wrap 7->0.
REQ-020 Digit idx SHALL show nibble shown[4*idx+3:4*idx] (idx 0 = least significant).
REQ-021 an and seg SHALL be registered, with 1-cycle latency from idx or shown change.
REQ-022 In BLANK, an SHALL be 8'hFF and seg SHALL be 8'hFF.
REQ-023 In SCAN, an SHALL be ~(8'b1<<idx) and seg[6:0] SHALL be the hex pattern of the selected nibble (0-F).
REQ-024 In SCAN, seg[7] (dp) SHALL be 1 (off).
REQ-025 In HALTED, an and seg[6:0] SHALL be as in SCAN, and dp SHALL be 0 (on) only when idx==0.
REQ-026 A ledValid on the same cycle as a tick SHALL update shown; the next registered seg SHALL reflect the new value.

Reset
REQ-027 On rst: state SHALL be BLANK, prescaler 0, idx 0, shown 0, an 8'hFF, seg 8'hFF.
REQ-028 rst SHALL take precedence over ledValid, halt and tick.
REQ-029 rst mid-scan SHALL restore reset values on the next edge with no residual digit.

Configuration
REQ-030 Macro SEG_LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-031 With SEG_LEADING_ZERO_BLANK_EN defined, in SCAN/HALTED a digit idx>0 whose nibble and all higher nibbles are 0 SHALL drive an bit high (off) and seg 8'hFF.
REQ-032 Digit 0 SHALL never be blanked, and the HALTED dp on digit 0 SHALL be unaffected by blanking.
REQ-033 Without SEG_LEADING_ZERO_BLANK_EN, all 8 digits SHALL always display, including zeros.

Structure
REQ-034 The shared CPU package SHALL hold the state enum (BLANK/SCAN/HALTED) and the 16-entry active-low seven-segment pattern constant.
REQ-035 The combinational sub-module seg_hex_decoder (4-bit nibble -> 7-bit pattern) SHALL be used by this block.
REQ-036 Prescaler, idx, FSM and output registers SHALL reside in seg_display_driver.

Verification (bench SCAN_DIV=4)
REQ-037 rst, no strobe for 40 cycles -> an=8'hFF, seg=8'hFF, shown=0 throughout.
REQ-038 ledValid with ledData=32'h1234ABCD -> state SCAN; with idx=0, seg[6:0]=7'h21 ('d'), an=8'hFE; every 4 cycles an rotates FE,FD,FB,...,7F,FE; idx=1 shows 'C'.
REQ-039 halt asserted with ledValid and ledData=32'h00000005 on the same cycle -> shown=5, state HALTED; dp=0 only while an=8'hFE; a later ledValid with ledData=32'hFFFFFFFF leaves shown=5.
REQ-040 SEG_LEADING_ZERO_BLANK_EN defined, shown=32'h00000A00 -> digits 3..7 off (an bit 1, seg 8'hFF); digits 0..2 show 0,0,A; without the macro, digits 3..7 show '0' (7'h40).
REQ-041 ledValid coincident with tick (ledData 32'h0 -> 32'h00000008) -> the next registered digit-0 output is '8' (7'h00).
REQ-042 rst while HALTED and idx=5 -> next cycle state BLANK, idx 0, an=8'hFF, dp off.

Source files
------------

// File: rtl/seg_display_driver_pkg.sv
// rtl/seg_display_driver_pkg.sv - display state enum and active-low seven-segment pattern table
package seg_display_driver_pkg;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SCAN   = 2'd1,
        HALTED = 2'd2
    } disp_state_e;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [7:0] AN_OFF     = 8'hFF;

    // Bit order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - combinational hex nibble to active-low seven-segment pattern
module seg_hex_decoder
    import seg_display_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] pattern_o
);

    assign pattern_o = SEG_PATTERNS[nibble_i];

endmodule

// File: rtl/seg_display_driver.sv
// rtl/seg_display_driver.sv - 8-digit multiplexed hex display driver; SEG_LEADING_ZERO_BLANK_EN enables leading-zero blanking
module seg_display_driver
    import seg_display_driver_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ledData,
    input  logic             ledValid,
    input  logic             halt,
    output logic [7:0]       an,
    output logic [7:0]       seg,
    output logic [WIDTH-1:0] shown
);

    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    disp_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [WIDTH-1:0] shown_q, shown_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    logic             tick;
    logic [3:0]       nibble;
    logic [6:0]       hex_pattern;
    logic             digit_blank;

    seg_hex_decoder u_hex_decoder (
        .nibble_i  (nibble),
        .pattern_o (hex_pattern)
    );

    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        idx_d   = tick ? idx_q + 3'd1 : idx_q;
        state_d = state_q;
        shown_d = shown_q;

        // halt is checked first so a simultaneous strobe still lands in HALTED.
        case (state_q)
            BLANK: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (ledValid) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (halt) begin
                    state_d = HALTED;
                end
            end
            default: ;
        endcase

        if (ledValid && (state_q != HALTED)) begin
            shown_d = ledData;
        end
    end

    always_comb begin
        nibble      = 4'(shown_q >> {idx_q, 2'b00});
        digit_blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        digit_blank = (idx_q != 3'd0) && ((shown_q >> {idx_q, 2'b00}) == '0);
`endif
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if ((state_q != BLANK) && !digit_blank) begin
            an_d  = ~(8'b1 << idx_q);
            // Decimal point on digit 0 marks a halted CPU.
            seg_d = {~((state_q == HALTED) && (idx_q == 3'd0)), hex_pattern};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shown_q <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shown_q <= shown_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign shown = shown_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// tb/tb_seg_display_driver.sv - scoreboard bench for seg_display_driver, honours SEG_LEADING_ZERO_BLANK_EN
module tb_seg_display_driver;

    localparam int SCAN_DIV = 4;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [31:0] ledData  = 32'h0;
    logic        ledValid = 1'b0;
    logic        halt     = 1'b0;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [31:0] shown;

    seg_display_driver #(
        .SCAN_DIV (SCAN_DIV),
        .WIDTH    (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ledData  (ledData),
        .ledValid (ledValid),
        .halt     (halt),
        .an       (an),
        .seg      (seg),
        .shown    (shown)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  an;
        logic [7:0]  seg;
        logic [31:0] shown;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [7:0] AN_ROT [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] an_t  [8];
    logic [7:0] seg_t [8];

    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                failures++;
                $display("FAIL %s missed cyc=%0d now=%0d", e.name, e.cyc, cyc);
            end else if (an !== e.an || seg !== e.seg || shown !== e.shown) begin
                failures++;
                $display("FAIL %s cyc=%0d got an=%h seg=%h shown=%h expected an=%h seg=%h shown=%h",
                         e.name, cyc, an, seg, shown, e.an, e.seg, e.shown);
            end
        end
    end

    task automatic push(input int c, input logic [7:0] a, input logic [7:0] s,
                        input logic [31:0] sh, input string nm);
        exp_t e;
        e.cyc = c; e.an = a; e.seg = s; e.shown = sh; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Output at r+n shows the digit selected after edge r+n-1.
    task automatic push_scan(input int r, input int n0, input int n1,
                             input logic [31:0] sh, input string nm);
        for (int n = n0; n <= n1; n++) begin
            int k;
            k = ((n - 1) / SCAN_DIV) % 8;
            push(r + n, an_t[k], seg_t[k], sh, nm);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(output int r);
        rst = 1'b1;
        step(1);
        r   = cyc;
        rst = 1'b0;
    endtask

    initial begin
        int r;
        step(1);

        // Idle after reset: nothing lit.
        do_reset(r);
        for (int n = 0; n <= 40; n++) push(r + n, 8'hFF, 8'hFF, 32'h0, "blank_idle");
        step(41);

        // Normal scan of 1234ABCD including wrap.
        do_reset(r);
        ledData = 32'h1234ABCD; ledValid = 1'b1;
        push(r + 1, 8'hFF, 8'hFF, 32'h1234ABCD, "scan_first");
        an_t  = AN_ROT;
        seg_t = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        push_scan(r, 2, 42, 32'h1234ABCD, "scan_1234abcd");
        step(1);
        ledValid = 1'b0;
        step(41);

        // halt with strobe: value latched, dp on digit 0, later strobes ignored.
        do_reset(r);
        halt = 1'b1; ledValid = 1'b1; ledData = 32'h00000005;
        push(r + 1, 8'hFF, 8'hFF, 32'h5, "halt_load");
        for (int k = 0; k < 8; k++) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
            an_t[k] = 8'hFF; seg_t[k] = 8'hFF;
`else
            an_t[k] = AN_ROT[k]; seg_t[k] = 8'hC0;
`endif
        end
        an_t[0] = 8'hFE; seg_t[0] = 8'h12;
        push_scan(r, 2, 34, 32'h5, "halted_dp");
        step(1);
        ledValid = 1'b0;
        step(8);
        ledValid = 1'b1; ledData = 32'hFFFFFFFF;
        step(1);
        ledValid = 1'b0;
        step(24);
        halt = 1'b0;

        // Leading-zero behaviour on 00000A00.
        do_reset(r);
        ledValid = 1'b1; ledData = 32'h00000A00;
        push(r + 1, 8'hFF, 8'hFF, 32'hA00, "lz_first");
        for (int k = 3; k < 8; k++) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
            an_t[k] = 8'hFF; seg_t[k] = 8'hFF;
`else
            an_t[k] = AN_ROT[k]; seg_t[k] = 8'hC0;
`endif
        end
        an_t[0] = 8'hFE; seg_t[0] = 8'hC0;
        an_t[1] = 8'hFD; seg_t[1] = 8'hC0;
        an_t[2] = 8'hFB; seg_t[2] = 8'h88;
        push_scan(r, 2, 34, 32'hA00, "lz_a00");
        step(1);
        ledValid = 1'b0;
        step(33);

        // Strobe on the tick that wraps idx 7->0.
        do_reset(r);
        ledValid = 1'b1; ledData = 32'h0;
        step(1);
        ledValid = 1'b0;
        step(30);
        ledValid = 1'b1; ledData = 32'h00000008;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        push(r + 32, 8'hFF, 8'hFF, 32'h8, "tick_pre");
`else
        push(r + 32, 8'h7F, 8'hC0, 32'h8, "tick_pre");
`endif
        push(r + 33, 8'hFE, 8'h80, 32'h8, "tick_load");
        step(1);
        ledValid = 1'b0;
        step(2);

        // Reset out of HALTED at idx 5, then BLANK accepts a strobe.
        do_reset(r);
        halt = 1'b1;
        step(1);
        halt = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        push(r + 21, 8'hFF, 8'hFF, 32'h0, "halt_idx5");
`else
        push(r + 21, 8'hDF, 8'hC0, 32'h0, "halt_idx5");
`endif
        step(20);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        push(r + 22, 8'hFF, 8'hFF, 32'h0, "rst_halted");
        ledValid = 1'b1; ledData = 32'h00000005;
        step(1);
        ledValid = 1'b0;
        push(r + 23, 8'hFF, 8'hFF, 32'h5, "post_rst_load");
        push(r + 24, 8'hFE, 8'h92, 32'h5, "post_rst_scan");
        step(3);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) step(1);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
